// File: rtl/dmem_io_pkg.sv
// Shared address map, store codes, timer register layout and byte-lane helpers
// for the data-side memory/I-O bridge.
package dmem_io_pkg;

    localparam logic [31:0] DMEM_BASE    = 32'h0000_0000;
    localparam logic [31:0] DMEM_LIMIT   = 32'h0000_0FFF;
    localparam logic [31:0] LED_ADDR     = 32'h0000_7F00;
    localparam logic [31:0] SW_ADDR      = 32'h0000_7F04;
    localparam logic [31:0] TCTRL_ADDR   = 32'h0000_7F10;
    localparam logic [31:0] TPRESET_ADDR = 32'h0000_7F14;
    localparam logic [31:0] TCOUNT_ADDR  = 32'h0000_7F18;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_WORD = 2'b01,
        MW_HALF = 2'b10,
        MW_BYTE = 2'b11
    } mw_e;

    localparam int unsigned TCTRL_EN   = 0;
    localparam int unsigned TCTRL_AUTO = 1;
    localparam int unsigned TCTRL_IRQ  = 2;

    typedef enum logic [1:0] {
        TSEL_NONE,
        TSEL_CTRL,
        TSEL_PRESET
    } tsel_e;

    // Byte-lane enables for a store; misaligned word/halfword stores yield no lanes.
    function automatic logic [3:0] lane_en(input mw_e mw, input logic [1:0] off);
        case (mw)
            MW_WORD: return (off == 2'b00) ? 4'b1111 : 4'b0000;
            MW_HALF: return off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
            MW_BYTE: return 4'b0001 << off;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input mw_e mw, input logic [31:0] wd);
        case (mw)
            MW_HALF: return {2{wd[15:0]}};
            MW_BYTE: return {4{wd[7:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/dmem_io_bridge_timer.sv
// Down-counting timer: TCTRL (EN/AUTO/IRQ), TPRESET and TCOUNT with a
// write-1-to-clear interrupt flag.
module io_timer
    import dmem_io_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  tsel_e       sel,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] preset_o,
    output logic [2:0]  ctrl_o,
    output logic        irq_o
);

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        irq_q, irq_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            irq_q    <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
        end else begin
            en_q     <= en_d;
            auto_q   <= auto_d;
            irq_q    <= irq_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    // Ordering encodes priority: hardware counting first, then register
    // writes (written EN and preset load win), then terminal-count IRQ set
    // overrides any W1C in the same cycle.
    always_comb begin
        en_d     = en_q;
        auto_d   = auto_q;
        irq_d    = irq_q;
        preset_d = preset_q;
        count_d  = count_q;
        term     = en_q && (count_q == '0);

        if (en_q) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else if (auto_q) begin
                count_d = preset_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (we && sel == TSEL_CTRL) begin
            en_d   = wdata[TCTRL_EN];
            auto_d = wdata[TCTRL_AUTO];
            if (wdata[TCTRL_IRQ]) begin
                irq_d = 1'b0;
            end
        end

        if (we && sel == TSEL_PRESET) begin
            preset_d = wdata;
            count_d  = wdata;
        end

        if (term) begin
            irq_d = 1'b1;
        end
    end

    always_comb begin
        ctrl_o             = '0;
        ctrl_o[TCTRL_EN]   = en_q;
        ctrl_o[TCTRL_AUTO] = auto_q;
        ctrl_o[TCTRL_IRQ]  = irq_q;
        count_o            = count_q;
        preset_o           = preset_q;
        irq_o              = irq_q;
    end

endmodule

// File: rtl/dmem_io_bridge.sv
// Data-side bridge for the single-cycle core: byte-lane DMEM, LED register,
// synchronized switches and a timer, all behind a combinational read mux.
module dmem_io_bridge
    import dmem_io_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 1024,
    parameter int unsigned SW_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic [1:0]      mem_write,
    output logic [31:0]     rdata,
    input  logic [SW_W-1:0] sw_in,
    output logic [SW_W-1:0] led_out,
    output logic            timer_irq
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);

    mw_e            mw;
    logic           hit_dmem, hit_led, hit_sw, hit_tctrl, hit_tpreset, hit_tcount;
    logic           word_store;
    logic [3:0]     be;
    logic [31:0]    wlanes;
    logic [AW-1:0]  dmem_idx;
    logic [SW_W-1:0] led_q, led_d;
    logic [SW_W-1:0] sync1_q, sync1_d;
    logic [SW_W-1:0] sync2_q, sync2_d;
    logic           tim_we;
    tsel_e          tim_sel;
    logic [31:0]    tim_count, tim_preset;
    logic [2:0]     tim_ctrl;
    logic           tim_irq;

    logic [31:0]    dmem_q [DMEM_WORDS];

    always_comb begin
        mw          = mw_e'(mem_write);
        hit_dmem    = (addr & ~DMEM_LIMIT) == DMEM_BASE;
        hit_led     = addr == LED_ADDR;
        hit_sw      = addr == SW_ADDR;
        hit_tctrl   = addr == TCTRL_ADDR;
        hit_tpreset = addr == TPRESET_ADDR;
        hit_tcount  = addr == TCOUNT_ADDR;
        word_store  = mw == MW_WORD;
        be          = hit_dmem ? lane_en(mw, addr[1:0]) : 4'b0000;
        wlanes      = lane_data(mw, wdata);
        dmem_idx    = addr[2 +: AW];

        tim_we  = word_store && (hit_tctrl || hit_tpreset);
        tim_sel = hit_tctrl ? TSEL_CTRL : (hit_tpreset ? TSEL_PRESET : TSEL_NONE);

        led_d = led_q;
        if (hit_led && word_store) begin
            led_d = wdata[SW_W-1:0];
        end
        sync1_d = sw_in;
        sync2_d = sync1_q;
    end

    // DMEM is not reset; lanes commit independently so partial stores keep
    // the untouched bytes.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                dmem_q[dmem_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            led_q   <= led_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    io_timer u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .we       (tim_we),
        .sel      (tim_sel),
        .wdata    (wdata),
        .count_o  (tim_count),
        .preset_o (tim_preset),
        .ctrl_o   (tim_ctrl),
        .irq_o    (tim_irq)
    );

    always_comb begin
        rdata = '0;
        if (hit_dmem) begin
            rdata = dmem_q[dmem_idx];
        end else if (hit_led) begin
            rdata[SW_W-1:0] = led_q;
        end else if (hit_sw) begin
            rdata[SW_W-1:0] = sync2_q;
        end else if (hit_tctrl) begin
            rdata[2:0] = tim_ctrl;
        end else if (hit_tpreset) begin
            rdata = tim_preset;
        end else if (hit_tcount) begin
            rdata = tim_count;
        end
    end

    always_comb begin
        led_out   = led_q;
        timer_irq = tim_irq;
    end

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Self-checking bench for dmem_io_bridge: directed vector table, timer/reset
// sequences and randomized stores checked against a byte-level memory model.
module tb_dmem_io_bridge;

    localparam logic [31:0] A_LED   = 32'h0000_7F00;
    localparam logic [31:0] A_SW    = 32'h0000_7F04;
    localparam logic [31:0] A_TCTRL = 32'h0000_7F10;
    localparam logic [31:0] A_TPRE  = 32'h0000_7F14;
    localparam logic [31:0] A_TCNT  = 32'h0000_7F18;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  mem_write;
    logic [15:0] sw_in, led_out;
    logic        timer_irq;

    always #10 clk = ~clk;

    dmem_io_bridge #(.DMEM_WORDS(1024), .SW_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .rdata     (rdata),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    int tests_run = 0;
    int fails = 0;

    logic [7:0]  ref_mem [0:4095];
    logic [15:0] ref_led;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  mw;
        logic [31:0] ra;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All tasks start just after a falling edge; store consumes exactly one rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
        addr = a;
        wdata = d;
        mem_write = mw;
        @(negedge clk);
        mem_write = 2'b00;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        mem_write = 2'b00;
        #1;
        check(name, rdata, exp);
    endtask

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
        int unsigned b;
        b = a;
        if (a < 32'h1000) begin
            case (mw)
                2'b01: if (a % 4 == 0) for (int k = 0; k < 4; k++) ref_mem[b+k] = d[8*k +: 8];
                2'b10: if (a % 2 == 0) begin
                    ref_mem[b]   = d[7:0];
                    ref_mem[b+1] = d[15:8];
                end
                2'b11: ref_mem[b] = d[7:0];
                default: ;
            endcase
        end else if (a == A_LED && mw == 2'b01) begin
            ref_led = d[15:0];
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned w;
        w = a - (a % 4);
        if (a < 32'h1000) return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
        if (a == A_LED) return {16'h0, ref_led};
        if (a == A_SW) return {16'h0, sw_in};
        return 32'h0;
    endfunction

    function automatic logic [31:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 6) return 32'($urandom_range(0, 255));
        if (r == 6) return A_LED;
        if (r == 7) return A_SW;
        if (r == 8) return 32'h1000 + 32'($urandom_range(0, 255));
        return $urandom | 32'h8000_0000;
    endfunction

    initial begin
        logic [31:0] a, d, ra;
        logic [1:0]  mw;

        vecs[0]  = '{32'h10,   32'hDEADBEEF, 2'b01, 32'h10,   32'hDEADBEEF, "word_st"};
        vecs[1]  = '{32'h12,   32'hFFFFFF55, 2'b11, 32'h10,   32'hDE55BEEF, "byte_st"};
        vecs[2]  = '{32'h10,   32'h9999A1B2, 2'b10, 32'h10,   32'hDE55A1B2, "half_lo"};
        vecs[3]  = '{32'h11,   32'h11111111, 2'b01, 32'h10,   32'hDE55A1B2, "word_misal"};
        vecs[4]  = '{32'h13,   32'h0000FFFF, 2'b10, 32'h10,   32'hDE55A1B2, "half_misal"};
        vecs[5]  = '{32'h10,   32'h00000000, 2'b00, 32'h10,   32'hDE55A1B2, "no_store"};
        vecs[6]  = '{32'h12,   32'h00007788, 2'b10, 32'h10,   32'h7788A1B2, "half_hi"};
        vecs[7]  = '{32'h13,   32'h00000099, 2'b11, 32'h10,   32'h9988A1B2, "byte_l3"};
        vecs[8]  = '{A_LED,    32'h000000A5, 2'b01, A_LED,    32'h000000A5, "led_word"};
        vecs[9]  = '{A_LED,    32'h000000FF, 2'b11, A_LED,    32'h000000A5, "led_byte"};
        vecs[10] = '{A_LED,    32'h0000FFFF, 2'b10, A_LED,    32'h000000A5, "led_half"};
        vecs[11] = '{32'h8000, 32'h12345678, 2'b01, 32'h8000, 32'h00000000, "unmapped"};
        vecs[12] = '{A_SW,     32'hCAFEF00D, 2'b01, A_SW,     32'h00000000, "sw_ro"};
        vecs[13] = '{32'h0,    32'h01020304, 2'b01, 32'h0,    32'h01020304, "word_0"};
        vecs[14] = '{32'h1000, 32'hFFFFFFFF, 2'b01, 32'h0,    32'h01020304, "no_alias"};
        vecs[15] = '{32'hFFC,  32'h0000ABCD, 2'b01, 32'hFFC,  32'h0000ABCD, "top_word"};
        vecs[16] = '{A_TCNT,   32'h00000007, 2'b01, A_TCNT,   32'h00000000, "tcount_ro"};
        vecs[17] = '{A_TPRE,   32'h00000033, 2'b11, A_TPRE,   32'h00000000, "tpre_byte"};

        rst = 1'b0;
        addr = '0;
        wdata = '0;
        mem_write = 2'b00;
        sw_in = '0;
        ref_led = '0;
        repeat (2) @(negedge clk);
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        rd(A_TCTRL, 32'h0, "rst_tctrl");
        rd(A_TCNT, 32'h0, "rst_tcount");
        rd(A_TPRE, 32'h0, "rst_tpreset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            store(vecs[i].a, vecs[i].d, vecs[i].mw);
            rd(vecs[i].ra, vecs[i].exp, vecs[i].name);
        end
        check("led_out", {16'h0, led_out}, 32'h000000A5);

        sw_in = 16'h1234;
        tick();
        rd(A_SW, 32'h0, "sw_plus1");
        tick();
        tick();
        rd(A_SW, 32'h1234, "sw_plus3");

        // Auto-reload timer
        store(A_TPRE, 32'd3, 2'b01);
        rd(A_TPRE, 32'd3, "tpre_rb");
        store(A_TCTRL, 32'b011, 2'b01);
        rd(A_TCNT, 32'd3, "auto_c3");
        tick(); rd(A_TCNT, 32'd2, "auto_c2");
        tick(); rd(A_TCNT, 32'd1, "auto_c1");
        tick(); rd(A_TCNT, 32'd0, "auto_c0");
        check("auto_irq_pre", {31'h0, timer_irq}, 32'h0);
        tick();
        check("auto_irq", {31'h0, timer_irq}, 32'h1);
        rd(A_TCNT, 32'd3, "auto_reload");
        store(A_TCTRL, 32'b100, 2'b01);
        check("w1c_irq", {31'h0, timer_irq}, 32'h0);
        rd(A_TCTRL, 32'h0, "w1c_ctrl");

        // One-shot
        store(A_TPRE, 32'd2, 2'b01);
        store(A_TCTRL, 32'b001, 2'b01);
        rd(A_TCNT, 32'd2, "os_c2");
        tick(); rd(A_TCNT, 32'd1, "os_c1");
        tick(); rd(A_TCNT, 32'd0, "os_c0");
        tick();
        check("os_irq", {31'h0, timer_irq}, 32'h1);
        rd(A_TCTRL, 32'b100, "os_ctrl");
        tick();
        rd(A_TCNT, 32'd0, "os_hold");
        store(A_TCTRL, 32'b100, 2'b01);
        check("os_clr", {31'h0, timer_irq}, 32'h0);

        // W1C in the terminal-count cycle: set wins, written EN wins
        store(A_TPRE, 32'd1, 2'b01);
        store(A_TCTRL, 32'b001, 2'b01);
        tick(); rd(A_TCNT, 32'd0, "tc_c0");
        store(A_TCTRL, 32'b101, 2'b01);
        check("tc_w1c_irq", {31'h0, timer_irq}, 32'h1);
        rd(A_TCTRL, 32'b101, "tc_w1c_ctrl");
        store(A_TCTRL, 32'b000, 2'b01);
        store(A_TCTRL, 32'b100, 2'b01);
        check("tc_clr", {31'h0, timer_irq}, 32'h0);

        // Clearing EN in the terminal-count cycle
        store(A_TPRE, 32'd1, 2'b01);
        store(A_TCTRL, 32'b011, 2'b01);
        tick(); rd(A_TCNT, 32'd0, "enclr_c0");
        store(A_TCTRL, 32'b010, 2'b01);
        check("enclr_irq", {31'h0, timer_irq}, 32'h1);
        rd(A_TCTRL, 32'b110, "enclr_ctrl");
        tick();
        rd(A_TCNT, 32'd1, "enclr_hold");
        store(A_TCTRL, 32'b100, 2'b01);

        // Preset load beats counting
        store(A_TPRE, 32'd5, 2'b01);
        store(A_TCTRL, 32'b001, 2'b01);
        tick(); rd(A_TCNT, 32'd4, "ld_c4");
        store(A_TPRE, 32'd9, 2'b01);
        rd(A_TCNT, 32'd9, "ld_prio");
        store(A_TCTRL, 32'b000, 2'b01);

        // Reset mid-count
        store(A_LED, 32'h5A, 2'b01);
        store(A_TPRE, 32'd2, 2'b01);
        store(A_TCTRL, 32'b011, 2'b01);
        tick(); tick(); tick();
        check("pre_rst_irq", {31'h0, timer_irq}, 32'h1);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_irq", {31'h0, timer_irq}, 32'h0);
        check("rst_mid_led", {16'h0, led_out}, 32'h0);
        rd(A_TCTRL, 32'h0, "rst_mid_tctrl");
        rd(A_TCNT, 32'h0, "rst_mid_tcount");
        rd(A_SW, 32'h0, "rst_mid_sw");
        rd(32'h8000, 32'h0, "rst_unmapped");
        rd(32'h0, 32'h01020304, "rst_dmem_rd");
        tick();
        rst = 1'b1;
        tick();
        rd(A_TCNT, 32'h0, "post_rst_cnt");

        // Randomized stores/reads against the byte-level model
        ref_led = '0;
        sw_in = 16'($urandom);
        tick(); tick(); tick();
        for (int w = 0; w < 64; w++) begin
            d = $urandom;
            store(32'(w * 4), d, 2'b01);
            model_store(32'(w * 4), d, 2'b01);
        end
        for (int n = 0; n < 300; n++) begin
            a = pick_addr();
            d = $urandom;
            mw = 2'($urandom_range(0, 3));
            store(a, d, mw);
            model_store(a, d, mw);
            ra = ($urandom_range(0, 1) == 1) ? a : pick_addr();
            rd(ra, model_read(ra), "rand");
        end
        check("rand_led", {16'h0, led_out}, {16'h0, ref_led});

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
